bn_updown_counter: RTL
======================

# bn_updown_counter

Parametrised N-digit, base-B synchronous counter with selectable up/down direction, synchronous parallel load and a cascade enable chain. It generalises the single-digit base-2 down counter to arbitrary base and digit count, so that several instances can be chained through `ei`/`eu` to build wider counters, timers or BCD displays. It is the standard counting primitive for the lab designs.

## Interface
Parameters:
- `BASE`, default 10, radix of each digit; legal range 2..16.
- `DIGITS`, default 4, number of digits; legal range 1..8.
- `W`, localparam, equals `$clog2(BASE)` (minimum 1), width of one digit.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `ei`  in  1  count enable in (carry/borrow from the less significant stage).
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `ld`  in  1  synchronous parallel load.
- `d`  in  DIGITS*W  load value; digit i is `d[i*W +: W]`.
- `q`  out  DIGITS*W  count value; digit i is `q[i*W +: W]`, digit 0 least significant.
- `eu`  out  1  count enable out (carry/borrow to the next stage).

## Operation
- Reset (`reset_`=0, asynchronous): every digit of `q` = 0 immediately, regardless of clock.
- Priority per rising edge: reset > `ld` > count > hold.
- Load: `ld`=1 → each digit takes its `d` value; a digit value ≥ BASE is saturated to BASE-1. `ei` and `up` are ignored on that edge.
- Count: `ld`=0, `ei`=1 → digit i steps when all digits j<i are at the terminal value for the current direction.
  - Terminal value: BASE-1 when `up`=1, 0 when `up`=0.
  - Up step: v → v+1; BASE-1 wraps to 0.
  - Down step: v → v-1; 0 wraps to BASE-1.
  - Digit 0 steps on every enabled edge.
- Hold: `ld`=0, `ei`=0 → `q` unchanged.
- `eu` is combinational: `eu` = `ei` & ~`ld` & (every digit at the terminal value). It asserts exactly on the cycle preceding the whole-counter wrap, so the next stage steps on the same edge.
- Direction change takes effect on the next edge. No state depends on the previous direction.
- Digits holding illegal values (only possible for BASE not a power of two, and only if forced) behave as follows. Up: the digit goes to 0. Down: the digit goes to BASE-2. This keeps the counter from locking up.
- Arithmetic is on W-bit digits. The wrap compare is done explicitly against BASE-1 and 0, never by relying on natural W-bit overflow.

## Timing
- Count and load latency: 1 cycle. `q` reflects the new value after the rising edge on which `ld` or `ei` was sampled high.
- `eu` has zero latency from `ei`, `ld` and `up`, and from `q` after the clock edge. Chained stages share the clock. The combinational `eu` path across k stages must meet one clock period.
- Reset deassertion is synchronous to the bench: release `reset_` away from the rising edge. The first count can occur on the first edge after release.
- Reset mid-count: `q` clears asynchronously. `eu` follows combinationally: with `ei`=1 and `up`=0, `eu` becomes 1 while in reset.

## Test plan
- Reset: set BASE=10, DIGITS=2. Hold `reset_`=0 with `ei`=1 for 2 cycles → `q`=0x00 and `eu`=1 (down). Release → first edge down-counts to 0x99, with `eu`=0.
- Up wrap and carry: set BASE=10, DIGITS=2, `up`=1, `ei`=1, starting from load 0x98. Next edges give 0x99 (with `eu`=1 while q=0x99), then 0x00 (`eu`=0).
- Non-power-of-two base: set BASE=6, DIGITS=1 (W=3), `up`=0, `ei`=1, from reset. Sequence is 0,5,4,3,2,1,0,5. `eu`=1 exactly when q=0.
- Load priority and saturation: set BASE=10, DIGITS=2. Drive `ld`=1 with `ei`=1 and `d`=0x3F → `q`=0x39 and `eu`=0 on that cycle. With `ei`=0 and `ld`=0 for 3 cycles, `q` holds 0x39.
- Direction switch: set BASE=16, DIGITS=2, `ei`=1. Load 0x0F, then do up for 1 edge → 0x10. Then down for 2 edges → 0x0F, then 0x0E.
- Cascade: chain two instances with BASE=2, DIGITS=1, feeding the first stage's `eu` into the second stage's `ei`, counting down from reset with `ei`=1 for 8 cycles. The combined {hi,lo} value follows 00,11,10,01,00,11,10,01,00.

Source files
------------

// File: rtl/bn_updown_counter.sv
// N-digit, base-B up/down counter with parallel load and a cascade enable chain.
// Each digit is its own instance. A digit steps when every lower digit sits at the terminal value.
module bn_digit #(
  parameter int BASE = 10,
  parameter int W    = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         step,
  input  logic         up,
  input  logic         ld,
  input  logic [W-1:0] dval,
  output logic [W-1:0] v,
  output logic         term
);
  localparam logic [W-1:0] MAX     = W'(BASE - 1);
  localparam logic [W-1:0] BASE_M2 = W'(BASE - 2);

  logic [W-1:0] nxt;

  // Wrap is compared explicitly against MAX and 0. Out-of-range codes steer
  // back into the legal range so a forced bad value cannot lock the digit.
  always_comb begin
    nxt = v;
    if (ld)
      nxt = (int'(dval) > BASE - 1) ? MAX : dval;
    else if (step) begin
      if (up)
        nxt = (v == MAX || int'(v) > BASE - 1) ? '0 : v + W'(1);
      else if (v == '0)
        nxt = MAX;
      else if (int'(v) > BASE - 1)
        nxt = BASE_M2;
      else
        nxt = v - W'(1);
    end
  end

  assign term = up ? (v == MAX) : (v == '0);

  always_ff @(posedge clock or negedge reset_)
    if (!reset_) v <= '0;
    else         v <= nxt;
endmodule

module bn_updown_counter #(
  parameter  int BASE   = 10,
  parameter  int DIGITS = 4,
  localparam int W      = (BASE > 2) ? $clog2(BASE) : 1
) (
  input  logic                clock,
  input  logic                reset_,
  input  logic                ei,
  input  logic                up,
  input  logic                ld,
  input  logic [DIGITS*W-1:0] d,
  output logic [DIGITS*W-1:0] q,
  output logic                eu
);
  logic [DIGITS-1:0][W-1:0] d_dig, q_dig;
  logic [DIGITS:0]          chain;
  logic [DIGITS-1:0]        term;

  assign d_dig    = d;
  assign q        = q_dig;
  assign chain[0] = ei;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign chain[i+1] = chain[i] & term[i];
    bn_digit #(.BASE(BASE), .W(W)) u_digit (
      .clock (clock),
      .reset_(reset_),
      .step  (chain[i] & ~ld),
      .up    (up),
      .ld    (ld),
      .dval  (d_dig[i]),
      .v     (q_dig[i]),
      .term  (term[i])
    );
  end

  assign eu = chain[DIGITS] & ~ld;
endmodule
